// File: rtl/st_pkg.sv
// Shared types and default geometry for the span sequencer and its tag pipe.
package st_pkg;

  localparam int unsigned ST_XW  = 12;
  localparam int unsigned ST_LAT = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_LOAD = 2'd1,
    ST_RUN  = 2'd2
  } st_state_e;

  // Pixel tag carried alongside the stepper pipeline (default x width).
  typedef struct packed {
    logic              valid;
    logic [ST_XW-1:0]  x;
    logic              last;
  } st_tag_t;

endpackage

// File: rtl/st_tag_pipe.sv
// LAT-deep stall-able shift register of pixel tags {valid, x, last}.
// Valid is the MSB of each tag; o_any_valid reports any occupied stage.
module st_tag_pipe #(
  parameter int unsigned TW  = 14,
  parameter int unsigned LAT = 2
) (
  input  logic          clk,
  input  logic          i_clr,
  input  logic          i_adv,
  input  logic [TW-1:0] i_tag,
  output logic [TW-1:0] o_tag,
  output logic          o_any_valid
);

  logic [TW-1:0] r_stage [LAT];

  // Shift one stage per advancing cycle; hold everything under stall.
  always_ff @(posedge clk) begin
    if (i_clr) begin
      for (int unsigned i = 0; i < LAT; i++) r_stage[i] <= '0;
    end else if (i_adv) begin
      r_stage[0] <= i_tag;
      for (int unsigned i = 1; i < LAT; i++) r_stage[i] <= r_stage[i-1];
    end
  end

  assign o_tag = r_stage[LAT-1];

  // OR of the valid bits across all stages.
  always_comb begin
    o_any_valid = 1'b0;
    for (int unsigned i = 0; i < LAT; i++) o_any_valid = o_any_valid | r_stage[i][TW-1];
  end

endmodule

// File: rtl/st_span_ctl.sv
// Span sequencer: accepts one span from the edge walker, issues the stepper
// load strobe, steps once per pixel honouring downstream stall, and emits a
// pixel tag stream delayed by LAT to line up with the stepper outputs.
// Optional perf counters are built when ST_SPAN_PERF_EN is defined.
module st_span_ctl
  import st_pkg::*;
#(
  parameter int unsigned XW  = ST_XW,
  parameter int unsigned LAT = ST_LAT
`ifdef ST_SPAN_PERF_EN
  , parameter int unsigned CW = 16
`endif
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          ew_st_valid,
  output logic          ew_st_ready,
  input  logic [XW-1:0] ew_st_xstart,
  input  logic [XW-1:0] ew_st_xend,
  input  logic          ew_st_left_major,
  input  logic          cc_st_stall,
  output logic          st_load,
  output logic          st_stall,
  output logic          st_left_major,
  output logic          st_pix_valid,
  output logic [XW-1:0] st_pix_x,
  output logic          st_pix_last,
  output logic          st_busy,
  output logic          st_span_done
`ifdef ST_SPAN_PERF_EN
  , output logic [CW-1:0] st_perf_spans
  , output logic [CW-1:0] st_perf_pixels
  , output logic [CW-1:0] st_perf_stalls
`endif
);

  localparam int unsigned   TW    = XW + 2;
  localparam logic [XW-1:0] X_ONE = {{(XW-1){1'b0}}, 1'b1};

  st_state_e     r_state, w_state_nxt;
  logic [XW-1:0] r_x, r_rem;
  logic          r_dir, r_empty_done;
  logic [XW:0]   w_cnt;
  logic          w_cnt_neg;
  logic          w_ready, w_accept, w_step, w_load, w_stall;
  logic [TW-1:0] w_tag_in, w_tag_out;
  logic          w_pipe_busy;

  // Signed pixel count minus one; negative means an empty span.
  assign w_cnt     = ew_st_left_major ? ({1'b0, ew_st_xend} - {1'b0, ew_st_xstart})
                                      : ({1'b0, ew_st_xstart} - {1'b0, ew_st_xend});
  assign w_cnt_neg = w_cnt[XW];

  // Next state, handshake and stepper controls; ready never looks at valid.
  always_comb begin
    w_state_nxt = r_state;
    w_ready     = 1'b0;
    w_accept    = 1'b0;
    w_step      = 1'b0;
    w_load      = 1'b0;
    w_stall     = 1'b1;
    case (r_state)
      ST_IDLE: w_ready = 1'b1;
      ST_LOAD: begin
        w_load      = 1'b1;
        w_state_nxt = ST_RUN;
      end
      ST_RUN: begin
        w_stall = cc_st_stall;
        w_step  = !cc_st_stall;
        w_ready = (r_rem == '0) && !cc_st_stall;
        if (w_step && (r_rem == '0)) w_state_nxt = ST_IDLE;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
    if (w_ready && ew_st_valid) begin
      w_accept    = 1'b1;
      w_state_nxt = w_cnt_neg ? ST_IDLE : ST_LOAD;
    end
  end

  // State, span position and direction registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_state      <= ST_IDLE;
      r_x          <= '0;
      r_rem        <= '0;
      r_dir        <= 1'b0;
      r_empty_done <= 1'b0;
    end else begin
      r_state      <= w_state_nxt;
      r_empty_done <= w_accept && w_cnt_neg;
      // A new span accepted on the final step overrides that step's update.
      if (w_accept && !w_cnt_neg) begin
        r_x   <= ew_st_xstart;
        r_rem <= w_cnt[XW-1:0];
        r_dir <= ew_st_left_major;
      end else if (w_step) begin
        r_x   <= r_dir ? (r_x + X_ONE) : (r_x - X_ONE);
        r_rem <= r_rem - X_ONE;
      end
    end
  end

  // Bubbles carry x=0 so idle outputs read as zero.
  assign w_tag_in = {w_step, (w_step ? r_x : {XW{1'b0}}), (w_step && (r_rem == '0))};

  st_tag_pipe #(
    .TW  (TW),
    .LAT (LAT)
  ) u_tag_pipe (
    .clk         (clk),
    .i_clr       (reset),
    .i_adv       (!cc_st_stall),
    .i_tag       (w_tag_in),
    .o_tag       (w_tag_out),
    .o_any_valid (w_pipe_busy)
  );

  assign st_pix_valid  = w_tag_out[TW-1];
  assign st_pix_x      = w_tag_out[TW-2:1];
  assign st_pix_last   = w_tag_out[0];
  assign st_span_done  = (st_pix_valid && st_pix_last && !cc_st_stall) || r_empty_done;
  assign st_busy       = (r_state != ST_IDLE) || w_pipe_busy;
  assign st_load       = w_load;
  assign st_stall      = w_stall;
  assign st_left_major = r_dir;
  // Held low while reset is asserted so every output except stall reads 0.
  assign ew_st_ready   = w_ready && !reset;

`ifdef ST_SPAN_PERF_EN
  logic [CW-1:0] r_perf_spans, r_perf_pixels, r_perf_stalls;

  // Saturating event counters.
  always_ff @(posedge clk) begin
    if (reset) begin
      r_perf_spans  <= '0;
      r_perf_pixels <= '0;
      r_perf_stalls <= '0;
    end else begin
      if (w_accept && !w_cnt_neg && (r_perf_spans != '1))
        r_perf_spans <= r_perf_spans + 1'b1;
      if (st_pix_valid && !cc_st_stall && (r_perf_pixels != '1))
        r_perf_pixels <= r_perf_pixels + 1'b1;
      if ((r_state == ST_RUN) && cc_st_stall && (r_perf_stalls != '1))
        r_perf_stalls <= r_perf_stalls + 1'b1;
    end
  end

  assign st_perf_spans  = r_perf_spans;
  assign st_perf_pixels = r_perf_pixels;
  assign st_perf_stalls = r_perf_stalls;
`endif

endmodule
